iaoq_pair: RTL and testbench

IAOQ_PAIR -- requirements
Module: iaoq_pair

---
 rtl/iaoq_pair.sv | 66 ++++++
 tb/tb_iaoq_pair.sv | 104 ++++++++++
 2 files changed

// File: rtl/iaoq_pair.sv
// iaoq_pair: PA-RISC style instruction address offset queue (front/back) with one buffered delayed-branch target.
module iaoq_pair #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int INC = 4,
  parameter int ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LE,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vec,
  output logic [WIDTH-1:0] front,
  output logic [WIDTH-1:0] back,
  output logic             pend_valid,
  output logic             br_drop
);
  typedef enum logic {RUN, PEND} state_t;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC);
  localparam logic [WIDTH-1:0] MASK = ~(WIDTH'((64'd1 << ALIGN_BITS) - 64'd1));
  state_t state, state_n;
  logic [WIDTH-1:0] front_n, back_n, tgt, tgt_n, br_a, trap_a;
  logic drop_n;
  assign br_a = br_target & MASK;
  assign trap_a = trap_vec & MASK;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      front <= RESET_VEC;
      back <= RESET_VEC + STEP;
      tgt <= '0;
      br_drop <= 1'b0;
    end else begin
      state <= state_n;
      front <= front_n;
      back <= back_n;
      tgt <= tgt_n;
      br_drop <= drop_n;
    end
  end
  always_comb begin
    state_n = state;
    front_n = front;
    back_n = back;
    tgt_n = tgt;
    drop_n = 1'b0;
    if (trap_valid) begin
      front_n = trap_a;
      back_n = trap_a + STEP;
      state_n = RUN;
    end else if (LE) begin
      front_n = back;
      back_n = (state == PEND) ? tgt : br_valid ? br_a : back + STEP;
      tgt_n = (state == PEND && br_valid) ? br_a : tgt;
      state_n = (state == PEND && br_valid) ? PEND : RUN;
    end else if (br_valid) begin
      // a second branch while one is already buffered has nowhere to go
      drop_n = (state == PEND);
      tgt_n = (state == PEND) ? tgt : br_a;
      state_n = PEND;
    end
  end
  always_comb pend_valid = (state == PEND);
endmodule

// File: tb/tb_iaoq_pair.sv
// tb_iaoq_pair: directed scenarios plus randomized traffic checked against a rule-level reference model.
module tb_iaoq_pair;
  logic clk = 0, reset = 1, LE = 0, br_valid = 0, trap_valid = 0;
  logic [31:0] br_target = 0, trap_vec = 0;
  logic [31:0] front, back;
  logic pend_valid, br_drop;
  int vectors = 0, miscompares = 0;
  logic armed = 0;
  logic [31:0] m_f, m_b, m_t;
  logic m_p, m_d;

  iaoq_pair dut (.clk(clk), .reset(reset), .LE(LE), .br_valid(br_valid), .br_target(br_target),
    .trap_valid(trap_valid), .trap_vec(trap_vec), .front(front), .back(back),
    .pend_valid(pend_valid), .br_drop(br_drop));

  always #5 clk = ~clk;

  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] nf, nb, nt;
    logic np, nd;
    nf = m_f; nb = m_b; nt = m_t; np = m_p; nd = 0;
    if (reset) begin
      nf = 0; nb = 4; nt = 0; np = 0;
      armed = 1;
    end else if (trap_valid) begin
      nf = al(trap_vec); nb = al(trap_vec) + 32'd4; np = 0;
    end else if (LE) begin
      nf = m_b;
      if (m_p) begin
        nb = m_t;
        if (br_valid) nt = al(br_target); else np = 0;
      end else nb = br_valid ? al(br_target) : m_b + 32'd4;
    end else if (br_valid) begin
      if (m_p) nd = 1;
      else begin nt = al(br_target); np = 1; end
    end
    m_f = nf; m_b = nb; m_t = nt; m_p = np; m_d = nd;
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    cmp("front", front, m_f);
    cmp("back", back, m_b);
    cmp("pend_valid", {31'd0, pend_valid}, {31'd0, m_p});
    cmp("br_drop", {31'd0, br_drop}, {31'd0, m_d});
  end

  task automatic step(input logic r, input logic le, input logic bv, input logic [31:0] bt,
                      input logic tv, input logic [31:0] tvec);
    reset = r; LE = le; br_valid = bv; br_target = bt; trap_valid = tv; trap_vec = tvec;
    @(posedge clk);
    #2;
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    cmp("rst_front", front, 32'h0); cmp("rst_back", back, 32'h4);
    cmp("rst_pend", {31'd0, pend_valid}, 0);
    step(0, 1, 0, 0, 0, 0); cmp("seq1", {front, back} >> 0 == {32'h4, 32'h8} ? 1 : 0, 1);
    step(0, 1, 0, 0, 0, 0); cmp("seq2_f", front, 32'h8); cmp("seq2_b", back, 32'hC);
    // delayed branch from 8/C
    step(0, 1, 1, 32'h103, 0, 0); cmp("br_f", front, 32'hC); cmp("br_b", back, 32'h100);
    step(0, 1, 0, 0, 0, 0); cmp("br2_f", front, 32'h100); cmp("br2_b", back, 32'h104);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h200, 0, 0);
    cmp("pend_f", front, 32'h4); cmp("pend_b", back, 32'h8); cmp("pend_v", {31'd0, pend_valid}, 1);
    step(0, 0, 1, 32'h300, 0, 0); cmp("drop", {31'd0, br_drop}, 1);
    step(0, 1, 0, 0, 0, 0);
    cmp("rel_f", front, 32'h8); cmp("rel_b", back, 32'h200);
    cmp("rel_v", {31'd0, pend_valid}, 0); cmp("rel_drop", {31'd0, br_drop}, 0);
    step(0, 0, 1, 32'h40, 0, 0);
    step(0, 1, 1, 32'h80, 1, 32'hC3);
    cmp("trap_f", front, 32'hC0); cmp("trap_b", back, 32'hC4); cmp("trap_v", {31'd0, pend_valid}, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFF8);
    step(0, 1, 0, 0, 0, 0); cmp("wrap_f", front, 32'hFFFF_FFFC); cmp("wrap_b", back, 32'h0);
    step(0, 0, 1, 32'h500, 0, 0);
    step(1, 1, 1, 32'h600, 1, 32'h700);
    cmp("rstp_f", front, 32'h0); cmp("rstp_b", back, 32'h4); cmp("rstp_v", {31'd0, pend_valid}, 0);
    step(0, 1, 0, 0, 0, 0); cmp("post_rst_b", back, 32'h8);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, t,
           $urandom_range(0, 15) == 0, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom);
    end
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
